// File: rtl/modport_stream.sv
// Byte-stream pass-through tap with an address-indexed register bank and transfer counter.
// Optional byte checksum output `sum` is built only when STREAM_SUM_EN is defined.
module modport_stream #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [31:0]       addr,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data_comb,
    output logic [DATA_W-1:0] out_data_registered,
    output logic              xfer,
    output logic [DATA_W-1:0] rd_data,
    output logic              addr_err,
    output logic [CNT_W-1:0]  xfer_count
`ifdef STREAM_SUM_EN
    ,
    output logic [CNT_W-1:0]  sum
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] data_q;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              wr_en;

    // Handshake is a pure pass-through; no state is held for it.
    assign in_ready      = out_ready;
    assign xfer          = in_valid & out_ready;
    assign out_data_comb = in_data;

    assign idx      = addr[IDX_W-1:0];
    assign in_range = (addr[31:IDX_W] == '0);
    assign wr_en    = xfer & in_range;

    assign rd_data             = in_range ? regs_q[idx] : '0;
    assign out_data_registered = data_q;
    assign addr_err            = err_q;
    assign xfer_count          = cnt_q;

    always_comb begin
        err_d = err_q;
        cnt_d = cnt_q;
        if (xfer) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!in_range) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            data_q <= in_data;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    // Bank write: read-during-write returns the old value until the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[idx] <= in_data;
        end
    end

`ifdef STREAM_SUM_EN
    logic [CNT_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (xfer) begin
            sum_d = sum_q + CNT_W'(in_data);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;
`endif

endmodule

// File: tb/tb_modport_stream.sv
// Self-checking bench for modport_stream: directed vector table plus reset, wrap and checksum sequences.
module tb_modport_stream;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned CNT_W    = 16;
    localparam int          NV       = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [31:0]       addr;
    logic              out_ready;
    logic [DATA_W-1:0] out_data_comb;
    logic [DATA_W-1:0] out_data_registered;
    logic              xfer;
    logic [DATA_W-1:0] rd_data;
    logic              addr_err;
    logic [CNT_W-1:0]  xfer_count;
`ifdef STREAM_SUM_EN
    logic [CNT_W-1:0]  sum;
    logic [CNT_W-1:0]  exp_sum;
`endif

    always #5 clk = ~clk;

    modport_stream #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_data             (in_data),
        .addr                (addr),
        .out_ready           (out_ready),
        .out_data_comb       (out_data_comb),
        .out_data_registered (out_data_registered),
        .xfer                (xfer),
        .rd_data             (rd_data),
        .addr_err            (addr_err),
        .xfer_count          (xfer_count)
`ifdef STREAM_SUM_EN
        ,
        .sum                 (sum)
`endif
    );

    typedef struct {
        logic        o_rdy;
        logic        i_vld;
        logic [7:0]  d;
        logic [31:0] a;
        logic        e_xfer;
        logic [7:0]  e_rd_pre;
        logic [7:0]  e_rd_post;
        logic [15:0] e_cnt;
        logic        e_err;
    } vec_t;

    vec_t vecs [NV];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic o, input logic v, input logic [7:0] d,
                                input logic [31:0] a, input logic ex, input logic [7:0] rp,
                                input logic [7:0] rq, input logic [15:0] c, input logic e);
        vec_t t;
        t.o_rdy = o; t.i_vld = v; t.d = d; t.a = a; t.e_xfer = ex;
        t.e_rd_pre = rp; t.e_rd_post = rq; t.e_cnt = c; t.e_err = e;
        return t;
    endfunction

    initial begin
        //            ordy vld data   addr          xfer rd_pre rd_post cnt err
        vecs[0]  = mk(1'b1, 1'b1, 8'h5A, 32'd2,        1'b1, 8'h00, 8'h5A, 16'd1, 1'b0);
        vecs[1]  = mk(1'b0, 1'b1, 8'h33, 32'd0,        1'b0, 8'h00, 8'h00, 16'd1, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, 8'h33, 32'd0,        1'b0, 8'h00, 8'h00, 16'd1, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, 8'h33, 32'd0,        1'b0, 8'h00, 8'h00, 16'd1, 1'b0);
        vecs[4]  = mk(1'b1, 1'b1, 8'h11, 32'd0,        1'b1, 8'h00, 8'h11, 16'd2, 1'b0);
        vecs[5]  = mk(1'b1, 1'b1, 8'h22, 32'd1,        1'b1, 8'h00, 8'h22, 16'd3, 1'b0);
        vecs[6]  = mk(1'b1, 1'b1, 8'h33, 32'd2,        1'b1, 8'h5A, 8'h33, 16'd4, 1'b0);
        vecs[7]  = mk(1'b1, 1'b1, 8'h44, 32'd3,        1'b1, 8'h00, 8'h44, 16'd5, 1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 8'h00, 32'd0,        1'b0, 8'h11, 8'h11, 16'd5, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 8'h00, 32'd1,        1'b0, 8'h22, 8'h22, 16'd5, 1'b0);
        vecs[10] = mk(1'b1, 1'b0, 8'h00, 32'd2,        1'b0, 8'h33, 8'h33, 16'd5, 1'b0);
        vecs[11] = mk(1'b1, 1'b0, 8'h00, 32'd3,        1'b0, 8'h44, 8'h44, 16'd5, 1'b0);
        vecs[12] = mk(1'b1, 1'b1, 8'hFF, 32'd4,        1'b1, 8'h00, 8'h00, 16'd6, 1'b1);
        vecs[13] = mk(1'b1, 1'b1, 8'h77, 32'd1,        1'b1, 8'h22, 8'h77, 16'd7, 1'b1);
        vecs[14] = mk(1'b1, 1'b1, 8'h01, 32'h8000_0001, 1'b1, 8'h00, 8'h00, 16'd8, 1'b1);
        vecs[15] = mk(1'b0, 1'b0, 8'hA5, 32'd1,        1'b0, 8'h77, 8'h77, 16'd8, 1'b1);

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 8'h00;
        addr      = 32'd0;
`ifdef STREAM_SUM_EN
        exp_sum   = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_reg", 32'(out_data_registered), 32'h0);
        check("rst_cnt", 32'(xfer_count), 32'h0);
        check("rst_err", 32'(addr_err), 32'h0);
        check("rst_rd", 32'(rd_data), 32'h0);
        reset_n = 1'b1;

        // Table: comb outputs before the edge, registered results after it.
        for (int i = 0; i < NV; i++) begin
            out_ready = vecs[i].o_rdy;
            in_valid  = vecs[i].i_vld;
            in_data   = vecs[i].d;
            addr      = vecs[i].a;
            #1;
            check($sformatf("v%0d_ready", i), 32'(in_ready), 32'(vecs[i].o_rdy));
            check($sformatf("v%0d_xfer", i), 32'(xfer), 32'(vecs[i].e_xfer));
            check($sformatf("v%0d_comb", i), 32'(out_data_comb), 32'(vecs[i].d));
            check($sformatf("v%0d_rd_pre", i), 32'(rd_data), 32'(vecs[i].e_rd_pre));
`ifdef STREAM_SUM_EN
            if (vecs[i].e_xfer) exp_sum = exp_sum + CNT_W'(vecs[i].d);
`endif
            @(posedge clk);
            #1;
            check($sformatf("v%0d_reg", i), 32'(out_data_registered), 32'(vecs[i].d));
            check($sformatf("v%0d_rd_post", i), 32'(rd_data), 32'(vecs[i].e_rd_post));
            check($sformatf("v%0d_cnt", i), 32'(xfer_count), 32'(vecs[i].e_cnt));
            check($sformatf("v%0d_err", i), 32'(addr_err), 32'(vecs[i].e_err));
`ifdef STREAM_SUM_EN
            check($sformatf("v%0d_sum", i), 32'(sum), 32'(exp_sum));
`endif
        end

        // Reset dropped mid-cycle while streaming clears everything immediately.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h99;
        addr      = 32'd1;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_reg", 32'(out_data_registered), 32'h0);
        check("arst_cnt", 32'(xfer_count), 32'h0);
        check("arst_err", 32'(addr_err), 32'h0);
        check("arst_rd", 32'(rd_data), 32'h0);
        check("arst_ready1", 32'(in_ready), 32'h1);
        out_ready = 1'b0;
        #1;
        check("arst_ready0", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("arst_nowr_rd", 32'(rd_data), 32'h0);
        check("arst_nowr_cnt", 32'(xfer_count), 32'h0);
        check("arst_nowr_reg", 32'(out_data_registered), 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_cnt", 32'(xfer_count), 32'h1);
        check("post_rst_rd", 32'(rd_data), 32'h99);
        check("post_rst_err", 32'(addr_err), 32'h0);

        // Counter wrap across 2^16 transfers.
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        in_data = 8'h00;
        addr    = 32'd0;
        repeat (65535) @(posedge clk);
        #1;
        check("cnt_max", 32'(xfer_count), 32'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        check("cnt_wrap", 32'(xfer_count), 32'h1);
        in_valid = 1'b0;

`ifdef STREAM_SUM_EN
        reset_n = 1'b0;
        #1;
        reset_n  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h80;
        @(posedge clk);
        #1;
        in_data = 8'h90;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("sum_80_90", 32'(sum), 32'h0110);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/modport_stream.md
# modport_stream

Single-clock byte-stream pass-through stage with an address-indexed register bank. It forwards downstream back-pressure to the upstream source and presents incoming data both combinationally and one cycle later. Each accepted byte is captured into a small register array selected by a 32-bit address bus that is driven as an input-only ("source" view) port. It sits between a byte producer and a consumer as a tap and loopback point.

## Interface
Parameters:
- DATA_W, 8, stream data width in bits.
- NUM_REGS, 4, register-bank depth; power of two, 2..256.
- CNT_W, 16, width of transfer counter and checksum.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream byte valid.
- in_ready  out  1  upstream may transfer.
- in_data  in  DATA_W  upstream byte.
- addr  in  32  register-bank address, source view; never driven by this block.
- out_ready  in  1  downstream ready.
- out_data_comb  out  DATA_W  combinational copy of in_data.
- out_data_registered  out  DATA_W  in_data delayed one clock.
- xfer  out  1  transfer strobe, in_valid AND in_ready.
- rd_data  out  DATA_W  bank readback at addr.
- addr_err  out  1  sticky out-of-range write flag.
- xfer_count  out  CNT_W  accepted-transfer count.
- sum  out  CNT_W  byte checksum; present only with STREAM_SUM_EN.

## Operation
- in_ready = out_ready, purely combinational, including during reset.
- xfer = in_valid & in_ready, combinational (primitive AND behaviour).
- out_data_comb = in_data, combinational.
- out_data_registered samples in_data on every rising clk edge, regardless of valid or ready.
- Index = addr[log2(NUM_REGS)-1:0]. An address is in range when addr[31:log2(NUM_REGS)] == 0.
- On xfer with an in-range address: regs[index] <= in_data.
- On xfer with an out-of-range address: no write; addr_err is set to 1 and holds until reset.
- rd_data = regs[index] combinationally when addr is in range, else 0.
- A write and a read to the same index in the same cycle: rd_data shows the old value that cycle and the new value afterwards.
- xfer_count increments by 1 per xfer and wraps from 2^CNT_W-1 to 0.
- Reset values: out_data_registered = 0, all regs = 0, addr_err = 0, xfer_count = 0, sum = 0.

## Timing
- in_ready, xfer, out_data_comb and rd_data have zero latency.
- out_data_registered has one-cycle latency.
- Bank writes, counter and checksum update on the edge where xfer = 1. They are visible in the following cycle.
- No handshake state is held. An upstream hold with in_valid = 1 and out_ready = 0 produces no writes or counts.
- Asserting reset_n low clears all state immediately, mid-transfer or not. No write completes on a clock edge while reset_n = 0.
- After reset_n rises, the first rising edge with xfer = 1 is accepted.

## Configuration
- STREAM_SUM_EN defined: the sum port exists. On each xfer, sum <= sum + zero-extended in_data, modulo 2^CNT_W.
- STREAM_SUM_EN undefined: the sum port and its accumulator are absent. All other behaviour is unchanged.

## Test plan
- Reset, then out_ready = 1, in_valid = 1, in_data = 0x5A, addr = 2 for one edge -> in_ready = 1, xfer = 1, out_data_comb = 0x5A same cycle; next cycle out_data_registered = 0x5A, rd_data = 0x5A, xfer_count = 1.
- out_ready = 0, in_valid = 1, in_data = 0x33, addr = 0 for 3 edges -> xfer = 0, regs[0] stays 0, xfer_count unchanged, out_data_registered = 0x33.
- Write 0x11, 0x22, 0x33, 0x44 to addr 0..3, then sweep addr 0..3 with in_valid = 0 -> rd_data = 0x11, 0x22, 0x33, 0x44.
- xfer with addr = 4 (NUM_REGS = 4) and in_data = 0xFF -> no bank change, rd_data = 0, addr_err = 1 and remains 1 after later valid writes; reset_n pulse clears it.
- 65537 consecutive transfers -> xfer_count = 1 (wrap). With STREAM_SUM_EN, bytes 0x80 and 0x90 -> sum = 0x0110.
- Assert reset_n low between clock edges during streaming -> all registered outputs 0 immediately, while in_ready still follows out_ready.
